// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM subcarrier mapper.
//   kind_e      : bin classification codes driven on m_kind
//   state_e     : mapper FSM states (IDLE waits for en at a symbol boundary)
//   LFSR_W/TAPS : pilot sign generator, x^7 + x^4 + 1 (Fibonacci, taps on bits 6 and 3)
//   n_null()    : null bins per symbol (DC plus the guard band)
//   n_data()    : data bins per symbol, evaluated at elaboration time only
package ofdm_pkg;

  typedef enum logic [1:0] {
    KIND_NULL  = 2'd0,
    KIND_PILOT = 2'd1,
    KIND_DATA  = 2'd2
  } kind_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int          LFSR_W    = 7;
  localparam logic [6:0]  LFSR_TAPS = 7'b100_1000;

  // DC bin plus the 2*n_guard guard bins around N_FFT/2.
  function automatic int n_null(input int n_guard);
    return 2 * n_guard + 1;
  endfunction

  // Constant function: data bins in one symbol for a given comb layout.
  function automatic int n_data(input int n_fft, input int n_guard,
                                input int spacing, input int offset);
    int cnt;
    cnt = 0;
    for (int k = 0; k < n_fft; k++) begin
      if (k == 0 || (k >= n_fft / 2 - n_guard && k <= n_fft / 2 + n_guard - 1)) continue;
      if (k % spacing == offset) continue;
      cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ofdm_pilot_lfsr.sv
// Pilot sign generator: 7-bit Fibonacci LFSR for x^7 + x^4 + 1.
//   clk   : system clock
//   rst   : asynchronous reset, active low; loads seed
//   step  : advance one position (once per emitted pilot)
//   seed  : reset state, must be nonzero; expected to be a static tie-off
//   sign  : current sign bit (register MSB); 1 means negative pilot
module ofdm_pilot_lfsr
  import ofdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic              sign
);

  logic [LFSR_W-1:0] lfsr;

  // Shift left, feedback is the XOR of the tapped bits (6 and 3).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= seed;
    end else if (step) begin
      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign sign = lfsr[LFSR_W-1];

endmodule

// File: rtl/ofdm_subcarrier_mapper.sv
// OFDM subcarrier mapper: emits one symbol of N_FFT bins between the QAM
// mapper and the IFFT. Bin 0 and the guard band around N_FFT/2 are null,
// a programmable comb carries BPSK pilots on I, all other bins carry QAM data.
//   clk, rst          : clock, asynchronous active-low reset
//   en                : run enable, only looked at when the bin counter is 0
//   s_valid/s_ready   : QAM input handshake, s_i/s_q signed I/Q
//   m_valid/m_ready   : output handshake, m_i/m_q signed bin I/Q
//   m_sop/m_eop       : first / last bin of a symbol
//   m_kind            : 0 null, 1 pilot, 2 data
//   sym_cnt           : symbols whose eop beat was accepted (wraps)
//   underrun          : sticky, a data bin waited two or more cycles for s_valid
//   dbg_state         : FSM state (0 IDLE, 1 RUN)
//
// Handshake: a beat transfers on a cycle where valid && ready are both high.
// The output register advances when adv = !m_valid || m_ready; while
// m_valid && !m_ready every m_* output holds. s_ready is high only on a data
// bin in RUN with adv, so s_ready never depends on s_valid.
module ofdm_subcarrier_mapper
  import ofdm_pkg::*;
#(
  parameter int                      N_FFT         = 1024,
  parameter int                      DW            = 16,
  parameter int                      N_GUARD       = 6,
  parameter int                      PILOT_SPACING = 14,
  parameter int                      PILOT_OFFSET  = 7,
  parameter logic signed [DW-1:0]    PILOT_AMP     = 16'sd8192,
  parameter logic [LFSR_W-1:0]       LFSR_SEED     = 7'h7F
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_i,
  input  logic [DW-1:0] s_q,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_i,
  output logic [DW-1:0] m_q,
  output logic          m_sop,
  output logic          m_eop,
  output logic [1:0]    m_kind,
  output logic [15:0]   sym_cnt,
  output logic          underrun,
  output logic          dbg_state
);

  localparam int            KW       = $clog2(N_FFT);
  localparam int            PW       = $clog2(PILOT_SPACING);
  localparam int            N_NULL   = n_null(N_GUARD);
  localparam logic [KW-1:0] NULL_LO  = KW'(N_FFT / 2 - N_GUARD);
  // N_NULL counts the DC bin too, hence the -2 for the last guard bin.
  localparam logic [KW-1:0] NULL_HI  = KW'(N_FFT / 2 - N_GUARD + N_NULL - 2);
  localparam logic [KW-1:0] K_LAST   = KW'(N_FFT - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(PILOT_SPACING - 1);
  localparam logic [PW-1:0] PH_PILOT = PW'(PILOT_OFFSET);

  state_e        state, state_nxt;
  logic [KW-1:0] k;      // bin index of the next bin to load
  logic [PW-1:0] ph;     // k mod PILOT_SPACING, kept as a counter
  kind_e         kind;
  logic          adv;
  logic          load;
  logic          waiting;
  logic          data_wait;
  logic          pilot_sign;
  logic          pilot_step;

  // Bin classifier: null wins over pilot, so a comb tooth in the guard band is null.
  always_comb begin
    kind = KIND_DATA;
    if (k == '0 || (k >= NULL_LO && k <= NULL_HI)) begin
      kind = KIND_NULL;
    end else if (ph == PH_PILOT) begin
      kind = KIND_PILOT;
    end
  end

  assign adv = !m_valid || m_ready;

  // Next-state and load decision. k == 0 in RUN is the symbol boundary:
  // with en low the FSM leaves once the eop beat has drained (adv), otherwise
  // bin 0 loads in the same cycle the eop beat is accepted (no bubble).
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    waiting   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en && k == '0) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (k == '0 && !en) begin
          if (adv) state_nxt = ST_IDLE;
        end else if (adv) begin
          load    = (kind != KIND_DATA) || s_valid;
          waiting = (kind == KIND_DATA) && !s_valid;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign s_ready    = (state == ST_RUN) && (kind == KIND_DATA) && adv;
  assign pilot_step = load && (kind == KIND_PILOT);
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k         <= '0;
      ph        <= '0;
      m_valid   <= 1'b0;
      m_i       <= '0;
      m_q       <= '0;
      m_sop     <= 1'b0;
      m_eop     <= 1'b0;
      m_kind    <= 2'd0;
      sym_cnt   <= '0;
      underrun  <= 1'b0;
      data_wait <= 1'b0;
    end else begin
      if (load) begin
        k       <= (k == K_LAST) ? '0 : k + 1'b1;
        // Phase restarts with every symbol because N_FFT need not be a
        // multiple of the comb period.
        ph      <= (k == K_LAST || ph == PH_LAST) ? '0 : ph + 1'b1;
        m_valid <= 1'b1;
        m_kind  <= kind;
        m_sop   <= (k == '0);
        m_eop   <= (k == K_LAST);
        case (kind)
          KIND_PILOT: begin
            m_i <= pilot_sign ? -PILOT_AMP : PILOT_AMP;
            m_q <= '0;
          end
          KIND_DATA: begin
            m_i <= s_i;
            m_q <= s_q;
          end
          default: begin
            m_i <= '0;
            m_q <= '0;
          end
        endcase
      end else if (adv) begin
        m_valid <= 1'b0;
      end

      if (m_valid && m_ready && m_eop) sym_cnt <= sym_cnt + 1'b1;

      // A one-cycle gap on s_valid is tolerated; the second consecutive one sticks.
      data_wait <= waiting;
      if (waiting && data_wait) underrun <= 1'b1;
    end
  end

  ofdm_pilot_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (pilot_step),
    .seed (LFSR_SEED),
    .sign (pilot_sign)
  );

endmodule
